// File: rtl/ysyx_2022040010_store_buf.sv
// In-order store buffer: formats execute-stage stores into 8-byte word writes with
// byte masks, queues them, drains to the data SRAM by req/gnt and flags load hazards.
module ysyx_2022040010_store_buf #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [3:0]    st_op,
    input  logic [63:0]   st_addr,
    input  logic [63:0]   st_data,
    output logic          st_misalign,
    output logic          dsram_req,
    output logic [63:0]   dsram_addr,
    output logic [63:0]   dsram_wdata,
    output logic [7:0]    dsram_wmask,
    input  logic          dsram_gnt,
    input  logic [63:0]   ld_addr,
    output logic          ld_conflict,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [60:0]      r_addr [DEPTH];
    logic [63:0]      r_data [DEPTH];
    logic [7:0]       r_mask [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_misalign;

    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_onehot;
    logic        w_misal;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_off;
    logic [63:0] w_fmt_data;
    logic [7:0]  w_fmt_mask;
    logic        w_conflict;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_accept = st_valid & ~w_full;
    assign w_onehot = (st_op != 4'd0) && ((st_op & (st_op - 4'd1)) == 4'd0);
    assign w_off    = st_addr[2:0];
    assign w_push   = w_accept & w_onehot & ~w_misal;
    assign w_pop    = ~w_empty & dsram_gnt;

    // Lane replication lets the SRAM take the word as-is; the mask selects the bytes.
    always_comb begin
        w_fmt_data = '0;
        w_fmt_mask = '0;
        w_misal    = 1'b0;
        case (st_op)
            4'b0001: begin
                w_fmt_data = {8{st_data[7:0]}};
                w_fmt_mask = 8'h01 << w_off;
            end
            4'b0010: begin
                w_fmt_data = {4{st_data[15:0]}};
                w_fmt_mask = 8'h03 << w_off;
                w_misal    = st_addr[0];
            end
            4'b0100: begin
                w_fmt_data = {2{st_data[31:0]}};
                w_fmt_mask = 8'h0F << w_off;
                w_misal    = |st_addr[1:0];
            end
            4'b1000: begin
                w_fmt_data = st_data;
                w_fmt_mask = 8'hFF;
                w_misal    = |st_addr[2:0];
            end
            default: begin
                w_fmt_data = '0;
                w_fmt_mask = '0;
                w_misal    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_accept & w_onehot & w_misal;
            if (w_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + PW'(1);
            end
            if (w_push) begin
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: it is only observed through valid/empty qualification.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= st_addr[63:3];
            r_data[r_wptr] <= w_fmt_data;
            r_mask[r_wptr] <= w_fmt_mask;
        end
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (((({r_addr[i], 3'b000}) ^ ld_addr) & ~64'h7) == 64'd0))
                w_conflict = 1'b1;
        end
    end

    assign st_ready    = ~w_full;
    assign st_misalign = r_misalign;
    assign dsram_req   = ~w_empty;
    assign dsram_addr  = w_empty ? 64'd0 : {r_addr[r_rptr], 3'b000};
    assign dsram_wdata = w_empty ? 64'd0 : r_data[r_rptr];
    assign dsram_wmask = w_empty ? 8'd0  : r_mask[r_rptr];
    assign ld_conflict = w_conflict;
    assign empty       = w_empty;
    assign count       = r_count;

endmodule

// File: tb/tb_ysyx_2022040010_store_buf.sv
// Directed bench for the store buffer: formatting, misalignment, full/drain ordering,
// simultaneous push/pop, load conflict detection and asynchronous reset.
module tb_ysyx_2022040010_store_buf;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [3:0] SB = 4'b0001;
    localparam logic [3:0] SH = 4'b0010;
    localparam logic [3:0] SW = 4'b0100;
    localparam logic [3:0] SD = 4'b1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          st_valid = 1'b0;
    logic          st_ready;
    logic [3:0]    st_op = 4'd0;
    logic [63:0]   st_addr = 64'd0;
    logic [63:0]   st_data = 64'd0;
    logic          st_misalign;
    logic          dsram_req;
    logic [63:0]   dsram_addr;
    logic [63:0]   dsram_wdata;
    logic [7:0]    dsram_wmask;
    logic          dsram_gnt = 1'b0;
    logic [63:0]   ld_addr = 64'd0;
    logic          ld_conflict;
    logic          empty;
    logic [CW-1:0] count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ysyx_2022040010_store_buf #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_ready(st_ready), .st_op(st_op),
        .st_addr(st_addr), .st_data(st_data), .st_misalign(st_misalign),
        .dsram_req(dsram_req), .dsram_addr(dsram_addr), .dsram_wdata(dsram_wdata),
        .dsram_wmask(dsram_wmask), .dsram_gnt(dsram_gnt),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic drive_store(input logic [3:0] op, input logic [63:0] a, input logic [63:0] d);
        st_valid = 1'b1; st_op = op; st_addr = a; st_data = d;
        @(posedge clk); #1;
        st_valid = 1'b0; st_op = 4'd0;
    endtask

    task automatic grant_one;
        dsram_gnt = 1'b1;
        @(posedge clk); #1;
        dsram_gnt = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        total_cnt++; if (st_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", st_ready); else pass_cnt++;
        total_cnt++; if (dsram_req !== 1'b0) $display("FAIL rst_req: got %b want 0", dsram_req); else pass_cnt++;
        total_cnt++; if (count !== 3'd0) $display("FAIL rst_count: got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty); else pass_cnt++;
        total_cnt++; if ({dsram_addr, dsram_wdata, dsram_wmask} !== 136'd0)
            $display("FAIL rst_bus: got %h/%h/%h want 0", dsram_addr, dsram_wdata, dsram_wmask); else pass_cnt++;
        total_cnt++; if ({st_misalign, ld_conflict} !== 2'b00)
            $display("FAIL rst_flags: got %b want 00", {st_misalign, ld_conflict}); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_sb;
        drive_store(SB, 64'h8000_0005, 64'hAB);
        total_cnt++; if (dsram_req !== 1'b1) $display("FAIL sb_req: got %b want 1", dsram_req); else pass_cnt++;
        total_cnt++; if (dsram_addr !== 64'h8000_0000) $display("FAIL sb_addr: got %h want 80000000", dsram_addr); else pass_cnt++;
        total_cnt++; if (dsram_wmask !== 8'h20) $display("FAIL sb_mask: got %h want 20", dsram_wmask); else pass_cnt++;
        total_cnt++; if (dsram_wdata !== 64'hABAB_ABAB_ABAB_ABAB) $display("FAIL sb_data: got %h want abababababababab", dsram_wdata); else pass_cnt++;
        total_cnt++; if (count !== 3'd1) $display("FAIL sb_count: got %0d want 1", count); else pass_cnt++;
        grant_one;
        total_cnt++; if (empty !== 1'b1) $display("FAIL sb_drain_empty: got %b want 1", empty); else pass_cnt++;
        total_cnt++; if (dsram_wmask !== 8'h00) $display("FAIL sb_drain_mask: got %h want 00", dsram_wmask); else pass_cnt++;
    endtask

    task automatic test_sw_sh;
        drive_store(SW, 64'h8000_000C, 64'h1234_5678);
        total_cnt++; if (dsram_wmask !== 8'hF0) $display("FAIL sw_mask: got %h want f0", dsram_wmask); else pass_cnt++;
        total_cnt++; if (dsram_wdata !== 64'h1234_5678_1234_5678) $display("FAIL sw_data: got %h want 1234567812345678", dsram_wdata); else pass_cnt++;
        total_cnt++; if (dsram_addr !== 64'h8000_0008) $display("FAIL sw_addr: got %h want 80000008", dsram_addr); else pass_cnt++;
        grant_one;
        drive_store(SH, 64'h8000_0006, 64'hBEEF);
        total_cnt++; if (dsram_wmask !== 8'hC0) $display("FAIL sh_mask: got %h want c0", dsram_wmask); else pass_cnt++;
        total_cnt++; if (dsram_wdata !== 64'hBEEF_BEEF_BEEF_BEEF) $display("FAIL sh_data: got %h want beefbeefbeefbeef", dsram_wdata); else pass_cnt++;
        grant_one;
        total_cnt++; if (empty !== 1'b1) $display("FAIL sh_drain_empty: got %b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_misalign;
        drive_store(SH, 64'h8000_0003, 64'h55);
        total_cnt++; if (st_misalign !== 1'b1) $display("FAIL mis_sh_pulse: got %b want 1", st_misalign); else pass_cnt++;
        total_cnt++; if (count !== 3'd0) $display("FAIL mis_sh_count: got %0d want 0", count); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (st_misalign !== 1'b0) $display("FAIL mis_sh_end: got %b want 0", st_misalign); else pass_cnt++;
        drive_store(SW, 64'h8000_0102, 64'h77);
        total_cnt++; if (st_misalign !== 1'b1) $display("FAIL mis_sw_pulse: got %b want 1", st_misalign); else pass_cnt++;
        drive_store(SD, 64'h104, 64'h99);
        total_cnt++; if (st_misalign !== 1'b1) $display("FAIL mis_sd_pulse: got %b want 1", st_misalign); else pass_cnt++;
        total_cnt++; if (dsram_req !== 1'b0) $display("FAIL mis_sd_req: got %b want 0", dsram_req); else pass_cnt++;
        drive_store(4'b0011, 64'h100, 64'h11);
        total_cnt++; if ({st_misalign, dsram_req} !== 2'b00)
            $display("FAIL badop_ignored: got mis/req %b want 00", {st_misalign, dsram_req}); else pass_cnt++;
    endtask

    task automatic test_full_drain;
        for (int i = 0; i < DEPTH; i++)
            drive_store(SD, 64'h100 + 64'(8 * i), 64'hD0D0_0000_0000_0000 | 64'(i));
        total_cnt++; if (count !== 3'd4) $display("FAIL full_count: got %0d want 4", count); else pass_cnt++;
        total_cnt++; if (st_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", st_ready); else pass_cnt++;
        drive_store(SD, 64'h120, 64'hEE);
        total_cnt++; if (count !== 3'd4) $display("FAIL full_reject: got %0d want 4", count); else pass_cnt++;
        dsram_gnt = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            total_cnt++; if (dsram_addr !== 64'h100 + 64'(8 * i))
                $display("FAIL drain_addr%0d: got %h want %h", i, dsram_addr, 64'h100 + 64'(8 * i)); else pass_cnt++;
            total_cnt++; if (dsram_wdata !== (64'hD0D0_0000_0000_0000 | 64'(i)))
                $display("FAIL drain_data%0d: got %h", i, dsram_wdata); else pass_cnt++;
            total_cnt++; if (dsram_wmask !== 8'hFF) $display("FAIL drain_mask%0d: got %h want ff", i, dsram_wmask); else pass_cnt++;
            @(posedge clk); #1;
            if (i == 0) begin
                total_cnt++; if (st_ready !== 1'b1) $display("FAIL drain_ready: got %b want 1", st_ready); else pass_cnt++;
            end
        end
        dsram_gnt = 1'b0;
        total_cnt++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_addr [4];
        exp_addr[0] = 64'h108; exp_addr[1] = 64'h110; exp_addr[2] = 64'h118; exp_addr[3] = 64'h300;
        for (int i = 0; i < DEPTH; i++)
            drive_store(SD, 64'h100 + 64'(8 * i), 64'(i));
        st_valid = 1'b1; st_op = SD; st_addr = 64'h300; st_data = 64'h33;
        dsram_gnt = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (count !== 3'd3) $display("FAIL simul_pop_only: got %0d want 3", count); else pass_cnt++;
        dsram_gnt = 1'b0;
        @(posedge clk); #1;
        st_valid = 1'b0; st_op = 4'd0;
        total_cnt++; if (count !== 3'd4) $display("FAIL simul_push_next: got %0d want 4", count); else pass_cnt++;
        dsram_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (dsram_addr !== exp_addr[i])
                $display("FAIL b2b_order%0d: got %h want %h", i, dsram_addr, exp_addr[i]); else pass_cnt++;
            @(posedge clk); #1;
        end
        dsram_gnt = 1'b0;
        total_cnt++; if (empty !== 1'b1) $display("FAIL b2b_empty: got %b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_ld_conflict;
        ld_addr = 64'h200;
        st_valid = 1'b1; st_op = SB; st_addr = 64'h200; st_data = 64'h5A;
        #1;
        total_cnt++; if (ld_conflict !== 1'b0) $display("FAIL ld_same_cycle: got %b want 0", ld_conflict); else pass_cnt++;
        @(posedge clk); #1;
        st_valid = 1'b0; st_op = 4'd0;
        ld_addr = 64'h207; #1;
        total_cnt++; if (ld_conflict !== 1'b1) $display("FAIL ld_hit: got %b want 1", ld_conflict); else pass_cnt++;
        ld_addr = 64'h208; #1;
        total_cnt++; if (ld_conflict !== 1'b0) $display("FAIL ld_next_word: got %b want 0", ld_conflict); else pass_cnt++;
        ld_addr = 64'h1FF; #1;
        total_cnt++; if (ld_conflict !== 1'b0) $display("FAIL ld_prev_word: got %b want 0", ld_conflict); else pass_cnt++;
        grant_one;
        ld_addr = 64'h207; #1;
        total_cnt++; if (ld_conflict !== 1'b0) $display("FAIL ld_after_drain: got %b want 0", ld_conflict); else pass_cnt++;
    endtask

    task automatic test_async_reset;
        drive_store(SD, 64'h500, 64'h1);
        drive_store(SD, 64'h508, 64'h2);
        drive_store(SD, 64'h510, 64'h3);
        total_cnt++; if (count !== 3'd3) $display("FAIL ar_pre_count: got %0d want 3", count); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        total_cnt++; if (dsram_req !== 1'b0) $display("FAIL ar_req: got %b want 0", dsram_req); else pass_cnt++;
        total_cnt++; if (count !== 3'd0) $display("FAIL ar_count: got %0d want 0", count); else pass_cnt++;
        total_cnt++; if (st_ready !== 1'b1) $display("FAIL ar_ready: got %b want 1", st_ready); else pass_cnt++;
        total_cnt++; if (dsram_addr !== 64'd0) $display("FAIL ar_addr: got %h want 0", dsram_addr); else pass_cnt++;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        drive_store(SD, 64'h600, 64'h66);
        total_cnt++; if (dsram_addr !== 64'h600) $display("FAIL ar_next_addr: got %h want 600", dsram_addr); else pass_cnt++;
        total_cnt++; if (count !== 3'd1) $display("FAIL ar_next_count: got %0d want 1", count); else pass_cnt++;
        grant_one;
        total_cnt++; if (empty !== 1'b1) $display("FAIL ar_final_empty: got %b want 1", empty); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_sb;
        test_sw_sh;
        test_misalign;
        test_full_drain;
        test_back_to_back;
        test_ld_conflict;
        test_async_reset;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
